// File: rtl/inst_prefetch.sv
// Instruction prefetch: two-word fetch from program RAM into a small FIFO.
// Define FETCH_CNT_EN to add the fetch_cnt handshake counter output.
module inst_prefetch #(
    parameter int            AW       = 10,
    parameter int            DEPTH    = 4,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clka,
    input  logic          rst,
    input  logic          fetch_en,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          mem_en,
    output logic [AW-1:0] mem_addr,
    input  logic [15:0]   mem_data,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [7:0]    inst_op,
    output logic [7:0]    inst_regnum,
    output logic [15:0]   inst_arg,
    output logic [AW-1:0] inst_pc
`ifdef FETCH_CNT_EN
    ,
    output logic [15:0]   fetch_cnt
`endif
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = 32 + AW;

    typedef enum logic [1:0] {
        FETCH_HI,
        FETCH_LO,
        COMPLETE
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_pc;
    logic [15:0]   r_hi;
    logic [EW-1:0] r_fifo [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_count;

    logic          w_push;
    logic          w_pop;
    logic          w_issue_hi;
    logic          w_issue_b2b;
    logic [CW-1:0] w_cnt_nxt;
    logic [EW-1:0] w_head;

    assign inst_valid  = (r_count != '0);
    assign w_pop       = inst_valid && inst_ready && !redirect_valid;
    assign w_push      = (r_state == COMPLETE) && !redirect_valid;
    assign w_cnt_nxt   = r_count + CW'(w_push) - CW'(w_pop);
    assign w_issue_hi  = (r_state == FETCH_HI) && fetch_en
                         && (r_count < CW'(DEPTH));
    assign w_issue_b2b = w_push && fetch_en && (w_cnt_nxt < CW'(DEPTH));
    assign w_head      = r_fifo[r_rd];

    // Fields read as zero whenever the FIFO is empty, including reset.
    assign {inst_op, inst_regnum, inst_arg, inst_pc} =
        inst_valid ? w_head : '0;

    always_comb begin
        mem_en   = 1'b0;
        mem_addr = '0;
        if (!rst && !redirect_valid) begin
            unique case (r_state)
                FETCH_HI: begin
                    if (w_issue_hi) begin
                        mem_en   = 1'b1;
                        mem_addr = r_pc;
                    end
                end
                FETCH_LO: begin
                    mem_en   = 1'b1;
                    mem_addr = r_pc + AW'(1);
                end
                COMPLETE: begin
                    if (w_issue_b2b) begin
                        mem_en   = 1'b1;
                        mem_addr = r_pc + AW'(2);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            r_state <= FETCH_HI;
            r_pc    <= RESET_PC;
            r_hi    <= '0;
            r_count <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
        end else if (redirect_valid) begin
            r_state <= FETCH_HI;
            r_pc    <= redirect_pc;
            r_count <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
        end else begin
            unique case (r_state)
                FETCH_HI: begin
                    if (w_issue_hi) r_state <= FETCH_LO;
                end
                FETCH_LO: begin
                    r_hi    <= mem_data;
                    r_state <= COMPLETE;
                end
                COMPLETE: begin
                    r_pc    <= r_pc + AW'(2);
                    r_state <= w_issue_b2b ? FETCH_LO : FETCH_HI;
                end
                default: r_state <= FETCH_HI;
            endcase
            if (w_push) r_wr <= r_wr + PW'(1);
            if (w_pop)  r_rd <= r_rd + PW'(1);
            r_count <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clka) begin
        if (w_push) r_fifo[r_wr] <= {r_hi, mem_data, r_pc};
    end

    // Every issue reserves a slot, so a push can never overflow.
    always @(posedge clka) begin
        if (!rst) begin
            assert (!(w_push && !w_pop && r_count == CW'(DEPTH)));
        end
    end

`ifdef FETCH_CNT_EN
    logic [15:0] r_fetch_cnt;

    always_ff @(posedge clka or posedge rst) begin
        if (rst)        r_fetch_cnt <= '0;
        else if (w_pop) r_fetch_cnt <= r_fetch_cnt + 16'd1;
    end

    assign fetch_cnt = r_fetch_cnt;
`endif

endmodule

// File: tb/tb_inst_prefetch.sv
// Bench for inst_prefetch: stream model checked every cycle plus
// directed scenarios with literal expectations.
module tb_inst_prefetch;
    logic        clka;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [9:0]  redirect_pc;
    logic        mem_en;
    logic [9:0]  mem_addr;
    logic [15:0] mem_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [7:0]  inst_op;
    logic [7:0]  inst_regnum;
    logic [15:0] inst_arg;
    logic [9:0]  inst_pc;
    logic [15:0] fetch_cnt;

    logic        b_en;
    logic [9:0]  b_addr;
    logic [15:0] b_data;
    logic        b_valid;
    logic [7:0]  b_op;
    logic [7:0]  b_reg;
    logic [15:0] b_arg;
    logic [9:0]  b_pc;
    logic [15:0] b_cnt;

    logic [15:0] ram [1024];

    int n_chk = 0;
    int n_pass = 0;

    inst_prefetch #(.AW(10), .DEPTH(4), .RESET_PC(10'h000)) u0 (
        .clka(clka), .rst(rst), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_data(mem_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_op(inst_op), .inst_regnum(inst_regnum),
        .inst_arg(inst_arg), .inst_pc(inst_pc)
`ifdef FETCH_CNT_EN
        , .fetch_cnt(fetch_cnt)
`endif
    );

    inst_prefetch #(.AW(10), .DEPTH(4), .RESET_PC(10'h3FE)) u1 (
        .clka(clka), .rst(rst), .fetch_en(1'b1),
        .redirect_valid(1'b0), .redirect_pc(10'h000),
        .mem_en(b_en), .mem_addr(b_addr), .mem_data(b_data),
        .inst_valid(b_valid), .inst_ready(1'b1),
        .inst_op(b_op), .inst_regnum(b_reg),
        .inst_arg(b_arg), .inst_pc(b_pc)
`ifdef FETCH_CNT_EN
        , .fetch_cnt(b_cnt)
`endif
    );

`ifndef FETCH_CNT_EN
    assign fetch_cnt = '0;
    assign b_cnt = '0;
`endif

    initial clka = 1'b0;
    always #5 clka = ~clka;

    // Registered RAM read ports.
    always @(posedge clka) if (mem_en) mem_data <= ram[mem_addr];
    always @(posedge clka) if (b_en) b_data <= ram[b_addr];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, got, exp);
    endtask

    task automatic nx();
        @(posedge clka);
        #1;
    endtask

    task automatic smp();
        @(negedge clka);
    endtask

    // Stream model: instructions appear in pc order from the restart
    // point; RAM reads are contiguous from the restart point.
    logic [9:0] m_pc;
    logic [9:0] m_fetch;
    logic       m_flushed;
    logic [15:0] m_hs;

    always @(negedge clka) begin
        if (rst) begin
            chk("m_rst_valid", inst_valid, 0);
            chk("m_rst_en", mem_en, 0);
            m_pc      = 10'h000;
            m_fetch   = 10'h000;
            m_flushed = 1'b1;
            m_hs      = 16'd0;
        end else begin
`ifdef FETCH_CNT_EN
            chk("m_fetch_cnt", fetch_cnt, m_hs);
`endif
            if (m_flushed) chk("m_flush_valid", inst_valid, 0);
            m_flushed = 1'b0;
            if (redirect_valid) begin
                chk("m_redir_en", mem_en, 0);
                m_pc      = redirect_pc;
                m_fetch   = redirect_pc;
                m_flushed = 1'b1;
            end else begin
                if (mem_en) begin
                    chk("m_addr", mem_addr, m_fetch);
                    m_fetch = m_fetch + 10'd1;
                end
                if (inst_valid) begin
                    chk("m_word0", {inst_op, inst_regnum}, ram[m_pc]);
                    chk("m_arg", inst_arg, ram[10'(m_pc + 10'd1)]);
                    chk("m_pc", inst_pc, m_pc);
                    if (inst_ready) begin
                        m_pc = m_pc + 10'd2;
                        m_hs = m_hs + 16'd1;
                    end
                end
            end
        end
    end

    // Capture of the wrap-around instance right after the first reset.
    logic       ph1;
    logic [9:0] wa [4];
    logic [9:0] wp [2];
    logic [15:0] wg;
    int na = 0;
    int np = 0;

    always @(negedge clka) begin
        if (ph1 && !rst) begin
            if (b_en && na < 4) begin
                wa[na] = b_addr;
                na++;
            end
            if (b_valid && np < 2) begin
                wp[np] = b_pc;
                if (np == 0) wg = b_arg;
                np++;
            end
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 16'(i * 40503) ^ 16'h5A5A;
        ram[0] = 16'h0401;
        ram[1] = 16'h1234;
        ram[2] = 16'h0502;
        ram[3] = 16'h0005;
        for (int i = 0; i < 4; i++) wa[i] = 10'h155;
        wp[0] = 10'h155;
        wp[1] = 10'h155;
        wg = 16'h0;

        rst = 1'b1;
        fetch_en = 1'b0;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 10'h000;
        ph1 = 1'b1;
        repeat (3) @(posedge clka);
        #1;
        chk("rst_en", mem_en, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_valid", inst_valid, 0);
        chk("rst_fields", {inst_op, inst_regnum, inst_arg}, 0);
        chk("rst_pc", inst_pc, 0);

        // Basic stream
        rst = 1'b0;
        fetch_en = 1'b1;
        inst_ready = 1'b1;
        smp();
        chk("c0_en", mem_en, 1);
        chk("c0_addr", mem_addr, 10'h000);
        nx(); smp();
        chk("c1_addr", mem_addr, 10'h001);
        nx(); smp();
        chk("c2_addr", mem_addr, 10'h002);
        chk("c2_valid", inst_valid, 0);
        nx(); smp();
        chk("c3_addr", mem_addr, 10'h003);
        chk("c3_valid", inst_valid, 1);
        chk("c3_word0", {inst_op, inst_regnum}, 16'h0401);
        chk("c3_arg", inst_arg, 16'h1234);
        chk("c3_pc", inst_pc, 10'h000);
        nx(); smp();
        chk("c4_valid", inst_valid, 0);
        nx(); smp();
        chk("c5_valid", inst_valid, 1);
        chk("c5_word0", {inst_op, inst_regnum}, 16'h0502);
        chk("c5_arg", inst_arg, 16'h0005);
        chk("c5_pc", inst_pc, 10'h002);
        repeat (10) nx();
        ph1 = 1'b0;

        // Fill with consumer stalled, then drain
        redirect_valid = 1'b1;
        redirect_pc = 10'h000;
        inst_ready = 1'b0;
        nx();
        redirect_valid = 1'b0;
        repeat (20) nx();
        smp();
        chk("full_valid", inst_valid, 1);
        chk("full_pc", inst_pc, 10'h000);
        chk("full_en", mem_en, 0);
        nx(); smp();
        chk("full_en2", mem_en, 0);
        nx();
        inst_ready = 1'b1;
        smp();
        chk("dr0_pc", inst_pc, 10'h000);
        chk("dr0_en", mem_en, 0);
        nx(); smp();
        chk("dr1_pc", inst_pc, 10'h002);
        chk("dr1_en", mem_en, 1);
        chk("dr1_addr", mem_addr, 10'h008);
        nx(); smp();
        chk("dr2_pc", inst_pc, 10'h004);
        chk("dr2_addr", mem_addr, 10'h009);
        nx(); smp();
        chk("dr3_pc", inst_pc, 10'h006);
        chk("dr3_addr", mem_addr, 10'h00A);
        nx(); smp();
        chk("dr4_valid", inst_valid, 1);
        chk("dr4_pc", inst_pc, 10'h008);

        // Redirect with 3 buffered entries and FETCH_LO active
        nx();
        redirect_valid = 1'b1;
        redirect_pc = 10'h000;
        inst_ready = 1'b0;
        nx();
        redirect_valid = 1'b0;
        repeat (7) nx();
        redirect_valid = 1'b1;
        redirect_pc = 10'h100;
        smp();
        chk("rd_head", inst_pc, 10'h000);
        chk("rd_en", mem_en, 0);
        nx();
        redirect_valid = 1'b0;
        smp();
        chk("rd1_valid", inst_valid, 0);
        chk("rd1_en", mem_en, 1);
        chk("rd1_addr", mem_addr, 10'h100);
        nx(); smp();
        chk("rd2_valid", inst_valid, 0);
        nx(); smp();
        chk("rd3_valid", inst_valid, 0);
        nx(); smp();
        chk("rd4_valid", inst_valid, 1);
        chk("rd4_pc", inst_pc, 10'h100);

        // Async reset in the COMPLETE cycle that fills the FIFO
        repeat (5) nx();
        chk("ar_pre_valid", inst_valid, 1);
        rst = 1'b1;
        #1;
        chk("ar_valid", inst_valid, 0);
        chk("ar_fields", {inst_op, inst_regnum, inst_arg}, 0);
        chk("ar_pc", inst_pc, 0);
        chk("ar_en", mem_en, 0);
        chk("ar_addr", mem_addr, 0);
        nx();
        rst = 1'b0;
        smp();
        chk("ar_restart_en", mem_en, 1);
        chk("ar_restart_addr", mem_addr, 10'h000);

        // Five handshakes, then a redirect
        repeat (20) nx();
`ifdef FETCH_CNT_EN
        chk("cnt_zero", fetch_cnt, 16'd0);
`endif
        inst_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            smp();
            chk("hs_valid", inst_valid, 1);
            chk("hs_pc", inst_pc, 10'(2 * k));
            nx();
        end
        inst_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 10'h200;
        smp();
`ifdef FETCH_CNT_EN
        chk("cnt_five", fetch_cnt, 16'd5);
`endif
        nx();
        redirect_valid = 1'b0;
        smp();
`ifdef FETCH_CNT_EN
        chk("cnt_after_redir", fetch_cnt, 16'd5);
`endif
        repeat (8) nx();

        // PC wrap on the RESET_PC=0x3FE instance
        chk("wrap_a0", wa[0], 10'h3FE);
        chk("wrap_a1", wa[1], 10'h3FF);
        chk("wrap_a2", wa[2], 10'h000);
        chk("wrap_a3", wa[3], 10'h001);
        chk("wrap_p0", wp[0], 10'h3FE);
        chk("wrap_arg0", wg, ram[10'h3FF]);
        chk("wrap_p1", wp[1], 10'h000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/inst_prefetch.md
Name: inst_prefetch

Overview:
- Fetch stage that sits directly upstream of the decode/execute stage.
- Reads 16-bit instruction words from the read port of the dual-port program RAM. Two words make one instruction: word0 = {op[7:0], regnum[7:0]}, word1 = 16-bit address/number.
- Assembles each instruction and buffers it in a small prefetch FIFO.
- Presents instructions to the decode stage over a valid/ready handshake.
- Supports redirect (jump, loop-back) with a full flush.

Parameters:
- AW, 10, program RAM address width; PC width.
- DEPTH, 4, prefetch FIFO depth in instructions; power of 2, at least 2.
- RESET_PC, 0, PC value loaded at reset.

Ports:
- clka  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous active-high reset.
- fetch_en  in  1  allows new fetches to be issued.
- redirect_valid  in  1  flush the FIFO and restart fetching at redirect_pc.
- redirect_pc  in  AW  new fetch address.
- mem_en  out  1  RAM read enable (drives enb).
- mem_addr  out  AW  RAM read address (drives addrb).
- mem_data  in  16  RAM read data (dob); registered, valid the cycle after mem_en.
- inst_valid  out  1  FIFO head holds a valid instruction.
- inst_ready  in  1  consumer accepts the head instruction.
- inst_op  out  8  head opcode.
- inst_regnum  out  8  head register number.
- inst_arg  out  16  head address/number word.
- inst_pc  out  AW  address of the head instruction's word0.

Behaviour:
- Reset (asynchronous, on rst high):
  - mem_en=0, mem_addr=0.
  - inst_valid=0; inst_op, inst_regnum, inst_arg and inst_pc all 0.
  - pc=RESET_PC; FIFO empty (count=0); state=FETCH_HI.
  - A reset mid-fetch discards the in-flight read.
- Outputs are driven combinationally from the FIFO head register. inst_valid = (count!=0).
- Pop on inst_valid && inst_ready. With an empty FIFO, inst_ready is ignored.
- FSM states:
  - FETCH_HI: if fetch_en && count<DEPTH, drive mem_en=1, mem_addr=pc, go to FETCH_LO. Otherwise mem_en=0 and stay.
  - FETCH_LO: mem_en=1, mem_addr=pc+1 (mod 2^AW). On the leaving edge, capture hi=mem_data. Go to COMPLETE.
  - COMPLETE: mem_data is the lo word. Push {hi[15:8], hi[7:0], mem_data, pc} and set pc<=pc+2 (mod 2^AW).
    - If fetch_en and count after this cycle's push/pop is below DEPTH, issue mem_en=1, mem_addr=pc+2 and go to FETCH_LO (back-to-back).
    - Otherwise go to FETCH_HI.
- Throughput is 1 instruction per 2 cycles.
- Latency: the HI issue cycle is cycle 0; the push happens in cycle 2; inst_valid=1 from cycle 3 when the FIFO was empty.
- No overflow is possible: an issue reserves a slot, and only pops occur in between. A push into a full FIFO must never happen; assert this in simulation.
- A simultaneous push and pop with count=DEPTH-1 or count=DEPTH is legal; count is unchanged.
- fetch_en low only blocks new HI issues. An instruction already in FETCH_LO/COMPLETE completes and is pushed.
- Redirect takes priority over everything in the same cycle:
  - FIFO cleared (count=0); any push and pop that cycle are dropped.
  - In-flight data discarded; pc<=redirect_pc; state<=FETCH_HI; mem_en=0 that cycle.
  - inst_valid is 0 in the following cycle.
  - The first instruction from the new PC is valid 4 cycles after the redirect cycle, given fetch_en=1.
- pc and the FIFO pointers wrap silently. An odd redirect_pc is legal: words are fetched at pc and pc+1 with no alignment check.

Optional Feature:
- FETCH_CNT_EN defined:
  - Adds output fetch_cnt, 16 bits: the number of instructions popped (handshakes) since reset.
  - Wraps 0xFFFF->0. Not cleared by redirect; cleared by rst.
- FETCH_CNT_EN undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- RAM[0..3]=0x0401,0x1234,0x0502,0x0005; rst pulse, fetch_en=1, inst_ready=1 -> mem_addr sequence 0,1,2,3. Instruction 1 (op=0x04, regnum=0x01, arg=0x1234, pc=0) valid 3 cycles after the first issue; instruction 2 (op=0x05, regnum=0x02, arg=0x0005, pc=2) follows 2 cycles later.
- inst_ready=0 with DEPTH=4 -> exactly 4 instructions buffered (pc 0,2,4,6), then mem_en stays 0. Raise inst_ready -> pops in order, and fetching resumes at pc=8.
- Redirect to 0x100 while the FIFO holds 3 entries and FETCH_LO is active -> next cycle inst_valid=0; the next mem_addr issued is 0x100; the first inst_pc delivered is 0x100.
- RESET_PC=0x3FE, AW=10 -> word reads at 0x3FE, 0x3FF; the next instruction is read at 0x000, 0x001 (wrap).
- rst asserted mid-COMPLETE with the FIFO full -> all outputs immediately 0, count=0, and fetching restarts at RESET_PC after rst drops.
- FETCH_CNT_EN defined, 5 handshakes followed by a redirect -> fetch_cnt=5, and the count is unchanged by the redirect.
